// File: rtl/src_control_unit.sv
// src_control_unit: Moore sequencer for a multi-cycle CPU datapath. It walks
// RESET -> T0..T7 (fetch plus execute) -> T0, or into a terminal HALT state.
// Each step drives a set of datapath strobes decoded from the state, the
// opcode field IR[31:27] and the CON flag.
module src_control_unit #(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        Run,
    output logic [4:0]  opcode,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin,
    output logic        Zhighout, Zlowout, HIin, HIout, LOin, LOout,
    output logic        read, write, CONin, R8_RAin, InPortout, Out_portIn
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_NEGNOT, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFLO, C_MFHI, C_HALT, C_NOP
    } class_e;

    state_e     state_q, state_d;
    logic [4:0] op_s;
    class_e     cls_s;
    state_e     last_s;
    logic       ir_unused_s;

    // Group opcodes by the control sequence they share.
    function automatic class_e op_class(input logic [4:0] op);
        case (op) inside
            5'd0:            op_class = C_LD;
            5'd1:            op_class = C_LDI;
            5'd2:            op_class = C_ST;
            [5'd3:5'd11]:    op_class = C_ALU;
            [5'd12:5'd14]:   op_class = C_IMM;
            5'd15, 5'd16:    op_class = C_MULDIV;
            5'd17, 5'd18:    op_class = C_NEGNOT;
            5'd19:           op_class = C_BR;
            5'd20:           op_class = C_JR;
            5'd21:           op_class = C_JAL;
            5'd22:           op_class = C_IN;
            5'd23:           op_class = C_OUT;
            5'd24:           op_class = C_MFLO;
            5'd25:           op_class = C_MFHI;
            5'd27:           op_class = C_HALT;
            default:         op_class = C_NOP;
        endcase
    endfunction

    // Final execute step of each class; the step after it is T0.
    function automatic state_e last_step(input class_e c);
        case (c)
            C_ALU, C_IMM, C_LDI: last_step = S_T5;
            C_LD, C_ST:          last_step = S_T7;
            C_MULDIV, C_BR:      last_step = S_T6;
            C_NEGNOT, C_JAL:     last_step = S_T4;
            default:             last_step = S_T3;
        endcase
    endfunction

    // ALU operation presented during execute steps.
    function automatic logic [4:0] alu_select(input logic [4:0] op);
        case (op) inside
            [5'd3:5'd11], [5'd15:5'd18]: alu_select = op;
            5'd13:                       alu_select = 5'b00101;
            5'd14:                       alu_select = 5'b00110;
            5'd0, 5'd1, 5'd2, 5'd12, 5'd19: alu_select = ADD_OP;
            default:                     alu_select = 5'b00000;
        endcase
    endfunction

    assign op_s   = IR[31:27];
    assign cls_s  = op_class(op_s);
    assign last_s = last_step(cls_s);
    // Operand fields are consumed by the datapath select/encode logic, not here.
    assign ir_unused_s = ^IR[26:0];

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                if (Stop) state_d = S_HALT;
                else      state_d = S_T1;
            end
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: begin
                if (cls_s == C_HALT)     state_d = S_HALT;
                else if (last_s == S_T3) state_d = S_T0;
                else                     state_d = S_T4;
            end
            S_T4, S_T5, S_T6: begin
                if (state_q == last_s) state_d = S_T0;
                else                   state_d = state_e'(state_q + 4'd1);
            end
            S_T7:   state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // State register; clear low forces RESET immediately.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    // Control decode; everything not named for a step stays low.
    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout, Cout} = 7'b0;
        {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin} = 9'b0;
        {Zhighout, Zlowout, HIin, HIout, LOin, LOout} = 6'b0;
        {read, write, CONin, R8_RAin, InPortout, Out_portIn} = 6'b0;
        Run    = 1'b0;
        opcode = 5'b00000;
        case (state_q)
            S_T0: begin
                Run = 1'b1;
                // A pending stop suppresses this fetch.
                PCout = !Stop; MARin = !Stop; IncPC = !Stop;
            end
            S_T1: begin Run = 1'b1; read = 1'b1; MDRin = 1'b1; end
            S_T2: begin Run = 1'b1; MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                Run = 1'b1; opcode = alu_select(op_s);
                case (cls_s)
                    C_ALU, C_IMM:       begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_LDI, C_LD, C_ST:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    C_MULDIV:           begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_NEGNOT:           begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                    C_BR:               begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    C_JR:               begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    C_JAL:              begin PCout = 1'b1; R8_RAin = 1'b1; end
                    C_IN:               begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_OUT:              begin Gra = 1'b1; Rout = 1'b1; Out_portIn = 1'b1; end
                    C_MFLO:             begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_MFHI:             begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default:            Run = 1'b1;
                endcase
            end
            S_T4: begin
                Run = 1'b1; opcode = alu_select(op_s);
                case (cls_s)
                    C_ALU:                     begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                    C_IMM, C_LDI, C_LD, C_ST:  begin Cout = 1'b1; Zin = 1'b1; end
                    C_MULDIV:                  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                    C_NEGNOT:                  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_BR:                      begin PCout = 1'b1; Yin = 1'b1; end
                    C_JAL:                     begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    default:                   Run = 1'b1;
                endcase
            end
            S_T5: begin
                Run = 1'b1; opcode = alu_select(op_s);
                case (cls_s)
                    C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_LD, C_ST:          begin Zlowout = 1'b1; MARin = 1'b1; end
                    C_MULDIV:            begin Zlowout = 1'b1; LOin = 1'b1; end
                    C_BR:                begin Cout = 1'b1; Zin = 1'b1; end
                    default:             Run = 1'b1;
                endcase
            end
            S_T6: begin
                Run = 1'b1; opcode = alu_select(op_s);
                case (cls_s)
                    C_LD:     begin read = 1'b1; MDRin = 1'b1; end
                    C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
                    C_BR:     begin Zlowout = 1'b1; PCin = CON; end
                    default:  Run = 1'b1;
                endcase
            end
            S_T7: begin
                Run = 1'b1; opcode = alu_select(op_s);
                case (cls_s)
                    C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_ST:    write = 1'b1;
                    default: Run = 1'b1;
                endcase
            end
            default: Run = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_src_control_unit.sv
// Directed bench for src_control_unit: walks reset, fetch and several
// instruction classes, comparing every strobe against hand-derived masks.
module tb_src_control_unit;

    logic        clock, clear, CON, Stop;
    logic [31:0] IR;
    logic        Run;
    logic [4:0]  opcode;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin;
    logic Zhighout, Zlowout, HIin, HIout, LOin, LOout;
    logic read, write, CONin, R8_RAin, InPortout, Out_portIn;

    int n_assert = 0;
    int n_fail   = 0;

    src_control_unit dut (
        .clock(clock), .clear(clear), .IR(IR), .CON(CON), .Stop(Stop),
        .Run(Run), .opcode(opcode),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .HIout(HIout),
        .LOin(LOin), .LOout(LOout),
        .read(read), .write(write), .CONin(CONin), .R8_RAin(R8_RAin),
        .InPortout(InPortout), .Out_portIn(Out_portIn)
    );

    logic [27:0] ctl;
    assign ctl = {Out_portIn, InPortout, R8_RAin, CONin, write, read, LOout, LOin,
                  HIout, HIin, Zlowout, Zhighout, Zin, Yin, IRin, MDRout, MDRin,
                  MARin, IncPC, PCin, PCout, Cout, BAout, Rout, Rin, Grc, Grb, Gra};

    localparam logic [27:0] GRA = 28'd1 << 0,  GRB = 28'd1 << 1,  GRC = 28'd1 << 2;
    localparam logic [27:0] RIN = 28'd1 << 3,  ROUT = 28'd1 << 4, BAOUT = 28'd1 << 5;
    localparam logic [27:0] COUT = 28'd1 << 6, PCOUT = 28'd1 << 7, PCIN = 28'd1 << 8;
    localparam logic [27:0] INCPC = 28'd1 << 9, MARIN = 28'd1 << 10, MDRIN = 28'd1 << 11;
    localparam logic [27:0] MDROUT = 28'd1 << 12, IRIN = 28'd1 << 13, YIN = 28'd1 << 14;
    localparam logic [27:0] ZIN = 28'd1 << 15, ZHIGH = 28'd1 << 16, ZLOW = 28'd1 << 17;
    localparam logic [27:0] HIIN = 28'd1 << 18, LOIN = 28'd1 << 20;
    localparam logic [27:0] READ = 28'd1 << 22, WRITE = 28'd1 << 23, CONIN = 28'd1 << 24;
    localparam logic [27:0] NONE = 28'd0;
    localparam logic [4:0]  ADDOP = 5'b00011;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [27:0] ectl, input logic erun,
                       input logic [4:0] eopc);
        n_assert++;
        assert (ctl === ectl) else begin
            n_fail++;
            $error("FAIL %s ctl observed=%h expected=%h", tag, ctl, ectl);
        end
        n_assert++;
        assert (Run === erun) else begin
            n_fail++;
            $error("FAIL %s Run observed=%b expected=%b", tag, Run, erun);
        end
        n_assert++;
        assert (opcode === eopc) else begin
            n_fail++;
            $error("FAIL %s opcode observed=%b expected=%b", tag, opcode, eopc);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Called while sampling T0; leaves the bench sampling T3.
    task automatic fetch(input string tag);
        chk({tag, "_T0"}, PCOUT | MARIN | INCPC, 1'b1, 5'd0); tick;
        chk({tag, "_T1"}, READ | MDRIN, 1'b1, 5'd0);          tick;
        chk({tag, "_T2"}, MDROUT | IRIN, 1'b1, 5'd0);         tick;
    endtask

    initial begin
        clear = 1'b1; IR = 32'h0; CON = 1'b0; Stop = 1'b0;
        #2 clear = 1'b0;
        #1 chk("reset_async", NONE, 1'b0, 5'd0);
        tick;
        chk("reset_held", NONE, 1'b0, 5'd0);
        clear = 1'b1;
        tick;

        // ld: 8 cycles
        IR = 32'h0000_0000;
        fetch("ld");
        chk("ld_T3", GRB | BAOUT | YIN, 1'b1, ADDOP);  tick;
        chk("ld_T4", COUT | ZIN, 1'b1, ADDOP);         tick;
        chk("ld_T5", ZLOW | MARIN, 1'b1, ADDOP);       tick;
        chk("ld_T6", READ | MDRIN, 1'b1, ADDOP);       tick;
        chk("ld_T7", MDROUT | GRA | RIN, 1'b1, ADDOP); tick;

        // second ld, cut by clear in T6
        fetch("ld2");
        tick; tick; tick;
        chk("ld2_T6", READ | MDRIN, 1'b1, ADDOP);
        #1 clear = 1'b0;
        #1 chk("clear_midinstr", NONE, 1'b0, 5'd0);
        tick;
        chk("clear_held", NONE, 1'b0, 5'd0);
        clear = 1'b1;
        tick;

        // add: 6 cycles
        IR = 32'h19A2_8000;
        fetch("add");
        chk("add_T3", GRB | ROUT | YIN, 1'b1, 5'b00011); tick;
        chk("add_T4", GRC | ROUT | ZIN, 1'b1, 5'b00011); tick;
        chk("add_T5", ZLOW | GRA | RIN, 1'b1, 5'b00011); tick;

        // andi
        IR = 32'h6800_0000;
        fetch("andi");
        chk("andi_T3", GRB | ROUT | YIN, 1'b1, 5'b00101); tick;
        chk("andi_T4", COUT | ZIN, 1'b1, 5'b00101);       tick;
        chk("andi_T5", ZLOW | GRA | RIN, 1'b1, 5'b00101); tick;

        // st
        IR = 32'h1000_0000;
        fetch("st");
        chk("st_T3", GRB | BAOUT | YIN, 1'b1, ADDOP);   tick;
        chk("st_T4", COUT | ZIN, 1'b1, ADDOP);          tick;
        chk("st_T5", ZLOW | MARIN, 1'b1, ADDOP);        tick;
        chk("st_T6", GRA | ROUT | MDRIN, 1'b1, ADDOP);  tick;
        chk("st_T7", WRITE, 1'b1, ADDOP);               tick;

        // br, CON=0 then CON=1
        IR = 32'h9800_0000; CON = 1'b0;
        fetch("br0");
        chk("br0_T3", GRA | ROUT | CONIN, 1'b1, ADDOP); tick;
        chk("br0_T4", PCOUT | YIN, 1'b1, ADDOP);        tick;
        chk("br0_T5", COUT | ZIN, 1'b1, ADDOP);         tick;
        chk("br0_T6", ZLOW, 1'b1, ADDOP);               tick;
        CON = 1'b1;
        fetch("br1");
        tick; tick; tick;
        chk("br1_T6", ZLOW | PCIN, 1'b1, ADDOP);        tick;

        // mul
        IR = 32'h8000_0000; CON = 1'b0;
        fetch("mul");
        chk("mul_T3", GRA | ROUT | YIN, 1'b1, 5'b10000); tick;
        chk("mul_T4", GRB | ROUT | ZIN, 1'b1, 5'b10000); tick;
        chk("mul_T5", ZLOW | LOIN, 1'b1, 5'b10000);      tick;
        chk("mul_T6", ZHIGH | HIIN, 1'b1, 5'b10000);     tick;

        // nop and an undefined opcode: empty T3 then back to T0
        IR = 32'hD000_0000;
        fetch("nop");
        chk("nop_T3", NONE, 1'b1, 5'd0); tick;
        IR = 32'hF800_0000;
        fetch("undef");
        chk("undef_T3", NONE, 1'b1, 5'd0); tick;

        // halt instruction
        IR = 32'hD800_0000;
        fetch("halt");
        chk("halt_T3", NONE, 1'b1, 5'd0);
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("halt_hold", NONE, 1'b0, 5'd0);
        end

        // Stop in T0
        clear = 1'b0; Stop = 1'b1;
        #1 clear = 1'b1;
        tick;
        chk("stop_T0", NONE, 1'b1, 5'd0);
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("stop_hold", NONE, 1'b0, 5'd0);
        end

        // recovery through clear
        clear = 1'b0; Stop = 1'b0;
        #1 clear = 1'b1;
        tick;
        chk("recover_T0", PCOUT | MARIN | INCPC, 1'b1, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/src_control_unit.md
SRC_CONTROL_UNIT -- requirements
Module: src_control_unit

Interface
REQ-001 Parameter ADD_OP, default 5'b00011, ALU opcode driven for address/offset arithmetic.
REQ-002 clock  in  1  sole clock; all state changes on rising edge.
REQ-003 clear  in  1  one clock; reset is asynchronous and active-low (port named clear; clear=0 resets).
REQ-004 IR  in  32  instruction register contents; opcode is IR[31:27].
REQ-005 CON  in  1  latched branch-condition flag from the CON flip-flop.
REQ-006 Stop  in  1  halt request.
REQ-007 Run  out  1  high while executing; low in reset and halt.
REQ-008 opcode  out  5  ALU operation select.
REQ-009 Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  register select/encode controls.
REQ-010 PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout  out  1 each  datapath strobes.
REQ-011 read, write, CONin, R8_RAin, InPortout, Out_portIn  out  1 each  memory, branch, link and I/O strobes.

Function
REQ-012 Moore FSM: states RESET, T0, T1, T2, T3..T7, HALT; controls are decoded from state plus IR/CON only; any control not listed for a step SHALL be 0.
REQ-013 RESET -> T0 on first edge after clear deasserts; Run=1 in T0..T7.
REQ-014 Fetch: T0 PCout,MARin,IncPC; T1 read,MDRin; T2 MDRout,IRin; T2 -> T3 always.
REQ-015 Opcodes: ld 00000, ldi 00001, st 00010, add..shl 00011-01011, addi 01100, andi 01101, ori 01110, div 01111, mul 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, mflo 11000, mfhi 11001, nop 11010, halt 11011.
REQ-016 opcode output = IR[31:27] for reg-reg ALU, mul, div, neg, not; 00101 for andi; 00110 for ori; ADD_OP for ld, ldi, st, addi, br; 0 otherwise.
REQ-017 Reg-reg ALU: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin; T5 Zlowout,Gra,Rin.
REQ-018 addi/andi/ori: T3 Grb,Rout,Yin; T4 Cout,Zin; T5 Zlowout,Gra,Rin.
REQ-019 ldi: T3 Grb,BAout,Yin; T4 Cout,Zin; T5 Zlowout,Gra,Rin.
REQ-020 ld: T3-T4 as ldi; T5 Zlowout,MARin; T6 read,MDRin; T7 MDRout,Gra,Rin.
REQ-021 st: T3-T5 as ld; T6 Gra,Rout,MDRin (read=0); T7 write.
REQ-022 mul/div: T3 Gra,Rout,Yin; T4 Grb,Rout,Zin; T5 Zlowout,LOin; T6 Zhighout,HIin.
REQ-023 neg/not: T3 Grb,Rout,Zin; T4 Zlowout,Gra,Rin.
REQ-024 br: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin; T6 Zlowout, PCin=CON.
REQ-025 jr: T3 Gra,Rout,PCin. jal: T3 PCout,R8_RAin; T4 Gra,Rout,PCin.
REQ-026 in: T3 InPortout,Gra,Rin. out: T3 Gra,Rout,Out_portIn. mflo/mfhi: T3 LOout/HIout,Gra,Rin.
REQ-027 nop and undefined opcodes (11100-11111): no T3 controls; T3 -> T0.
REQ-028 After an instruction's last listed step, next state is T0; total cycles = 3 fetch + execute steps.
REQ-029 halt at T3 -> HALT; Stop=1 sampled in T0 -> HALT (that fetch not performed past T0, T0 controls suppressed).
REQ-030 HALT is terminal: all controls 0, Run=0, exit only via clear.

Reset
REQ-031 clear=0 at any time, including mid-instruction, SHALL immediately force state RESET, Run=0, all control outputs 0 and opcode=0, without waiting for a clock edge.

Verification
REQ-032 Reset: clear=0 mid-ld at T6 -> read=0 and MDRin=0 at once; release clear -> edge 1: RESET->T0; in T0 PCout=MARin=IncPC=1, Run=1.
REQ-033 add: IR=0x19A28000 -> T3 Grb/Rout/Yin, T4 Grc/Rout/Zin with opcode=00011, T5 Zlowout/Gra/Rin, next cycle T0; 6 cycles total.
REQ-034 ld: IR=0x00000000 -> T5 Zlowout/MARin, T6 read/MDRin, T7 MDRout/Gra/Rin; 8 cycles total.
REQ-035 br: IR=0x98000000, CON=0 -> T6 Zlowout=1, PCin=0; repeat with CON=1 -> PCin=1.
REQ-036 halt: IR=0xD8000000 -> Run=0 from next cycle, all controls 0 for 20 cycles; Stop=1 in T0 -> HALT likewise.
REQ-037 mul: IR=0x80000000 -> T5 LOin, T6 HIin, opcode=10000 throughout T3-T6.
